// File: rtl/mnist_l0_pkg.sv
// mnist_l0_pkg: shared geometry, FSM states and beat-counter type for the layer-0 frame packer
package mnist_l0_pkg;
  localparam int PIXEL_W = 8;
  localparam int NUM_PIXELS = 784;
  localparam int BEAT_PIXELS = 8;
  localparam int BEATS = NUM_PIXELS / BEAT_PIXELS;
  localparam int THRESH = 127;
  typedef enum logic [1:0] {FILL, HOLD, DRAIN} state_t;
  typedef logic [$clog2(BEATS)-1:0] beat_cnt_t;
endpackage

// File: rtl/mnist_l0_binarise.sv
// mnist_l0_binarise: one unsigned comparator per lane, pixel > THRESH gives 1
module mnist_l0_binarise #(
  parameter int PIXEL_W = mnist_l0_pkg::PIXEL_W,
  parameter int BEAT_PIXELS = mnist_l0_pkg::BEAT_PIXELS,
  parameter int THRESH = mnist_l0_pkg::THRESH
) (
  input  logic [BEAT_PIXELS*PIXEL_W-1:0] pix,
  output logic [BEAT_PIXELS-1:0]         bits
);
  import mnist_l0_pkg::*;
  for (genvar i = 0; i < BEAT_PIXELS; i++) begin : g_lane
    assign bits[i] = pix[i*PIXEL_W +: PIXEL_W] > PIXEL_W'(THRESH);
  end
endmodule

// File: rtl/mnist_l0_frame_packer.sv
// mnist_l0_frame_packer: binarise streamed pixels and pack one image into the layer-0 input vector
// Define MNIST_L0_PACK_DBUF_EN to add a shadow fill buffer so frames stream back to back
module mnist_l0_frame_packer #(
  parameter int PIXEL_W = mnist_l0_pkg::PIXEL_W,
  parameter int NUM_PIXELS = mnist_l0_pkg::NUM_PIXELS,
  parameter int BEAT_PIXELS = mnist_l0_pkg::BEAT_PIXELS,
  parameter int THRESH = mnist_l0_pkg::THRESH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [BEAT_PIXELS*PIXEL_W-1:0] s_data,
  input  logic                           s_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [NUM_PIXELS-1:0]          m_frame,
  output logic                           err_short,
  output logic                           err_long,
  output logic [15:0]                    frame_cnt
);
  import mnist_l0_pkg::*;
  localparam int NB = NUM_PIXELS / BEAT_PIXELS;
  localparam int CW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);
  if (NUM_PIXELS % BEAT_PIXELS != 0) begin : g_geom_chk
    $error("NUM_PIXELS must be a multiple of BEAT_PIXELS");
  end
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BEAT_PIXELS-1:0] lanes;
  logic [NUM_PIXELS-1:0] fill, fill_w;
  logic fill_beat, at_last, done, short_f, overrun, drain_end, hs, hold_on_done, m_valid_n;
  mnist_l0_binarise #(
    .PIXEL_W(PIXEL_W),
    .BEAT_PIXELS(BEAT_PIXELS),
    .THRESH(THRESH)
  ) u_bin (
    .pix(s_data),
    .bits(lanes)
  );
  always_comb begin
    fill_beat = s_valid && s_ready && st == FILL;
    at_last = cnt == LAST;
    done = fill_beat && at_last && s_last;
    short_f = fill_beat && !at_last && s_last;
    overrun = fill_beat && at_last && !s_last;
    drain_end = s_valid && s_ready && st == DRAIN && s_last;
    hs = m_valid && m_ready;
`ifdef MNIST_L0_PACK_DBUF_EN
    hold_on_done = m_valid && !m_ready;
    m_valid_n = done || st == HOLD || (m_valid && !m_ready);
`else
    hold_on_done = 1'b1;
    m_valid_n = done || (m_valid && !m_ready);
`endif
    cnt_n = (done || short_f || overrun) ? '0 : fill_beat ? cnt + CW'(1) : cnt;
    st_n = overrun ? DRAIN : drain_end ? FILL : done ? (hold_on_done ? HOLD : FILL) :
           (st == HOLD && m_ready) ? FILL : st;
    fill_w = fill;
    if (fill_beat) fill_w[int'(cnt)*BEAT_PIXELS +: BEAT_PIXELS] = lanes;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= FILL;
      cnt <= '0;
      fill <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      err_short <= 1'b0;
      err_long <= 1'b0;
      frame_cnt <= '0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      fill <= fill_w;
      s_ready <= st_n != HOLD;
      m_valid <= m_valid_n;
      err_short <= short_f;
      err_long <= drain_end;
      frame_cnt <= frame_cnt + 16'(hs);
    end
  end
`ifdef MNIST_L0_PACK_DBUF_EN
  // the shadow frame is swapped in on the handshake so m_valid never drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_frame <= '0;
    else if (done && !hold_on_done) m_frame <= fill_w;
    else if (st == HOLD && m_ready) m_frame <= fill;
  end
`else
  assign m_frame = fill;
`endif
endmodule
